// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg: definitions shared by the cmd_arb arbiter and its picker.
//   state_e : FSM encoding (IDLE, ISSUE, WAIT_REL; 2'b11 is unused)
//   clog2   : ceiling log2, used to size index and counter fields
package cmd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ISSUE    = 2'b01,
    WAIT_REL = 2'b10
  } state_e;

  // Ceiling log2 of value; yields 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cmd_arb_rr_pick.sv
// cmd_arb_rr_pick: combinational round-robin picker.
// Ports:
//   req   in  NREQ : request vector
//   ptr   in  IDW  : index where the upward search starts
//   valid out 1    : at least one request is set
//   idx   out IDW  : first set request at or above ptr, wrapping modulo NREQ
module cmd_arb_rr_pick
  import cmd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  logic           found_s;
  logic [IDW-1:0] idx_s;
  logic [IDW-1:0] cand_s;

  // Walk the requesters upward from ptr, wrapping, and keep the first hit.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    cand_s  = {IDW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cand_s = IDW'((int'(ptr) + i) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        idx_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign valid = found_s;
  assign idx   = idx_s;

endmodule

// File: rtl/cmd_arb.sv
// cmd_arb: round-robin arbiter sharing one downstream command/ack channel
// between NREQ requesters.
// Optional feature macro: CMD_ARB_TIMEOUT_EN (abort ISSUE after TMO_CYCLES).
// Ports:
//   clk      in  1            : clock, rising edge
//   reset    in  1            : synchronous, active-high
//   req_cmd  in  NREQ         : level command per requester
//   req_code in  NREQ*CODE_W  : code of requester i at [i*CODE_W +: CODE_W]
//   req_ack  out NREQ         : one-cycle ack pulse to the grantee
//   req_err  out NREQ         : one-cycle timeout pulse (0 without the macro)
//   dn_cmd   out 1            : shared command, high while awaiting dn_ack
//   dn_code  out CODE_W       : latched code of the grantee
//   dn_ack   in  1            : downstream acknowledge
//   grant_id out clog2(NREQ)  : current or last grantee
//   busy     out 1            : high in ISSUE and WAIT_REL
module cmd_arb
  import cmd_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int CODE_W     = 8,
  parameter int TMO_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_cmd,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  output logic [NREQ-1:0]          req_ack,
  output logic [NREQ-1:0]          req_err,
  output logic                     dn_cmd,
  output logic [CODE_W-1:0]        dn_code,
  input  logic                     dn_ack,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int IDW = clog2(NREQ);

  state_e            state_r, state_s;
  logic [IDW-1:0]    ptr_r, ptr_s;
  logic [IDW-1:0]    grant_id_r, grant_id_s;
  logic [CODE_W-1:0] dn_code_r, dn_code_s;
  logic              dn_cmd_r, dn_cmd_s;
  logic              busy_r, busy_s;
  logic [NREQ-1:0]   req_ack_r, req_ack_s;

  logic              pick_valid_s;
  logic [IDW-1:0]    pick_idx_s;
  logic [CODE_W-1:0] code_arr_s [NREQ];

`ifdef CMD_ARB_TIMEOUT_EN
  // Counter must hold values up to TMO_CYCLES-1.
  localparam int TMO_W = clog2(TMO_CYCLES + 1);
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
  logic [NREQ-1:0]   req_err_r, req_err_s;
`else
  // The timeout length has no effect when the counter is not built.
  localparam int tmo_cycles_unused = TMO_CYCLES;
`endif

  cmd_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_cmd),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Unpack the flat code bus so the grant path can index by requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      code_arr_s[i] = req_code[i*CODE_W +: CODE_W];
    end
  end

  // Next-state, pointer, latch and output-pulse decisions.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    grant_id_s = grant_id_r;
    dn_code_s  = dn_code_r;
    dn_cmd_s   = dn_cmd_r;
    busy_s     = busy_r;
    req_ack_s  = {NREQ{1'b0}};
`ifdef CMD_ARB_TIMEOUT_EN
    req_err_s  = {NREQ{1'b0}};
    tmo_cnt_s  = tmo_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        // dn_ack is deliberately not looked at here.
        if (pick_valid_s) begin
          state_s    = ISSUE;
          grant_id_s = pick_idx_s;
          dn_code_s  = code_arr_s[pick_idx_s];
          dn_cmd_s   = 1'b1;
          busy_s     = 1'b1;
`ifdef CMD_ARB_TIMEOUT_EN
          tmo_cnt_s  = {TMO_W{1'b0}};
`endif
        end else begin
          dn_cmd_s = 1'b0;
          busy_s   = 1'b0;
        end
      end
      ISSUE: begin
        // An early-dropped req_cmd is ignored: the command still completes.
        if (dn_ack) begin
          state_s               = WAIT_REL;
          dn_cmd_s              = 1'b0;
          req_ack_s[grant_id_r] = 1'b1;
        end
`ifdef CMD_ARB_TIMEOUT_EN
        // Ack has priority over a timeout landing on the same edge.
        else if (tmo_cnt_r == TMO_W'(TMO_CYCLES - 1)) begin
          state_s               = WAIT_REL;
          dn_cmd_s              = 1'b0;
          req_err_s[grant_id_r] = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
        end
`else
        else begin
          dn_cmd_s = 1'b1;
        end
`endif
      end
      WAIT_REL: begin
        // No arbitration until the grantee has released its command.
        if (!req_cmd[grant_id_r]) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          if (grant_id_r == IDW'(NREQ - 1)) begin
            ptr_s = {IDW{1'b0}};
          end else begin
            ptr_s = grant_id_r + IDW'(1);
          end
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s    = IDLE;
        grant_id_s = {IDW{1'b0}};
        dn_code_s  = {CODE_W{1'b0}};
        dn_cmd_s   = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State register, rotate pointer, grant latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {IDW{1'b0}};
      grant_id_r <= {IDW{1'b0}};
      dn_code_r  <= {CODE_W{1'b0}};
      dn_cmd_r   <= 1'b0;
      busy_r     <= 1'b0;
      req_ack_r  <= {NREQ{1'b0}};
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      grant_id_r <= grant_id_s;
      dn_code_r  <= dn_code_s;
      dn_cmd_r   <= dn_cmd_s;
      busy_r     <= busy_s;
      req_ack_r  <= req_ack_s;
    end
  end

`ifdef CMD_ARB_TIMEOUT_EN
  // ISSUE-cycle counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
      req_err_r <= {NREQ{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_s;
      req_err_r <= req_err_s;
    end
  end

  assign req_err = req_err_r;
`else
  assign req_err = {NREQ{1'b0}};
`endif

  assign req_ack  = req_ack_r;
  assign dn_cmd   = dn_cmd_r;
  assign dn_code  = dn_code_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;

endmodule
